traffic_sequencer: RTL

- Self-timed, parametrised traffic-light sequencer for N_APPROACH approaches.
- Replaces the externally driven decoder path. Green/amber/all-red phase timing, approach rotation and amber flashing are generated internally from a divided tick.
- Sits between the board clock and the `semaforos` lamp outputs.
- The ESP32 only selects the mode and can request a green hold.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/traffic_sequencer_tick_gen.sv | 28 ++
 rtl/traffic_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic-light sequencer.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        AMBER  = 2'd2,
        FLASH  = 2'd3
    } phase_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_AMB = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // mode[1] set selects amber flash regardless of mode[0]
    localparam logic [1:0] MODE_AUTO  = 2'b00;
    localparam logic [1:0] MODE_STOP  = 2'b01;
    localparam logic [1:0] MODE_FLASH = 2'b10;

endpackage

// File: rtl/traffic_sequencer_tick_gen.sv
// Free-running clock divider producing a one-cycle tick at TICK_HZ.
module tick_gen #(
    parameter int CLK_HZ  = 27_000_000,
    parameter int TICK_HZ = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_sequencer.sv
// Self-timed traffic-light sequencer: rotates green/amber/all-red over N approaches.
// state  | meaning
// ALLRED | every approach red; clearance or stop hold
// GREEN  | active approach green, others red
// AMBER  | active approach amber, others red
// FLASH  | all approaches flash amber on the tick
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int N_APPROACH = 4,
    parameter int CLK_HZ     = 27_000_000,
    parameter int TICK_HZ    = 2,
    parameter int GREEN_T    = 20,
    parameter int AMBER_T    = 6,
    parameter int ALLRED_T   = 2,
    parameter int MAX_HOLD_T = 40
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic                          hold,
    output logic [3*N_APPROACH-1:0]       semaforos,
    output logic [$clog2(N_APPROACH)-1:0] active_idx,
    output logic [1:0]                    phase,
    output logic                          tick_o
);

    localparam int IW    = $clog2(N_APPROACH);
    localparam int T_MAX = (GREEN_T > AMBER_T)
                         ? ((GREEN_T > ALLRED_T) ? GREEN_T : ALLRED_T)
                         : ((AMBER_T > ALLRED_T) ? AMBER_T : ALLRED_T);
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int HW    = (MAX_HOLD_T > 0) ? $clog2(MAX_HOLD_T + 1) : 1;

    phase_t                  state, state_d;
    logic [TW-1:0]           timer, timer_d;
    logic [IW-1:0]           idx_d, idx_inc;
    logic [HW-1:0]           hcnt, hcnt_d;
    logic                    toggle, toggle_d;
    logic                    tick, timer_end;
    logic [3*N_APPROACH-1:0] lamp_d;

    tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign tick_o    = tick;
    assign phase     = state;
    assign timer_end = (timer <= TW'(1));
    assign idx_inc   = (active_idx == IW'(N_APPROACH - 1)) ? '0 : active_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ALLRED;
            timer      <= TW'(ALLRED_T);
            active_idx <= '0;
            hcnt       <= '0;
            toggle     <= 1'b1;
            semaforos  <= {N_APPROACH{LAMP_RED}};
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            active_idx <= idx_d;
            hcnt       <= hcnt_d;
            toggle     <= toggle_d;
            semaforos  <= lamp_d;
        end
    end

    always_comb begin
        state_d  = state;
        timer_d  = timer;
        idx_d    = active_idx;
        hcnt_d   = hcnt;
        toggle_d = toggle;
        if (mode[1]) begin
            state_d = FLASH;
            if (state != FLASH) begin
                toggle_d = 1'b1;
            end else if (tick) begin
                toggle_d = ~toggle;
            end
        end else begin
            case (state)
                FLASH: begin
                    idx_d = '0;
                    if (ALLRED_T == 0 && mode == MODE_AUTO) begin
                        state_d = GREEN;
                        timer_d = TW'(GREEN_T);
                        hcnt_d  = '0;
                    end else begin
                        state_d = ALLRED;
                        timer_d = TW'(ALLRED_T);
                    end
                end
                ALLRED: begin
                    // Stop mode keeps the clearance timer primed for a clean restart
                    if (mode == MODE_STOP) begin
                        timer_d = TW'(ALLRED_T);
                    end else if (tick) begin
                        if (timer_end) begin
                            state_d = GREEN;
                            timer_d = TW'(GREEN_T);
                            hcnt_d  = '0;
                        end else begin
                            timer_d = timer - 1'b1;
                        end
                    end
                end
                GREEN: begin
                    if (tick) begin
                        if (mode == MODE_STOP) begin
                            state_d = AMBER;
                            timer_d = TW'(AMBER_T);
                        end else if (hold && hcnt < HW'(MAX_HOLD_T)) begin
                            hcnt_d = hcnt + 1'b1;
                        end else if (timer_end) begin
                            state_d = AMBER;
                            timer_d = TW'(AMBER_T);
                        end else begin
                            timer_d = timer - 1'b1;
                        end
                    end
                end
                AMBER: begin
                    if (tick) begin
                        if (timer_end) begin
                            idx_d = idx_inc;
                            if (ALLRED_T == 0 && mode == MODE_AUTO) begin
                                state_d = GREEN;
                                timer_d = TW'(GREEN_T);
                                hcnt_d  = '0;
                            end else begin
                                state_d = ALLRED;
                                timer_d = TW'(ALLRED_T);
                            end
                        end else begin
                            timer_d = timer - 1'b1;
                        end
                    end
                end
                default: state_d = ALLRED;
            endcase
        end
    end

    always_comb begin
        lamp_d = {N_APPROACH{LAMP_RED}};
        case (state)
            GREEN:   lamp_d[3*int'(active_idx) +: 3] = LAMP_GRN;
            AMBER:   lamp_d[3*int'(active_idx) +: 3] = LAMP_AMB;
            FLASH:   lamp_d = toggle ? {N_APPROACH{LAMP_AMB}} : {N_APPROACH{LAMP_OFF}};
            default: lamp_d = {N_APPROACH{LAMP_RED}};
        endcase
    end

endmodule
